// File: rtl/dtw_query_sequencer_if.sv
// Bundles every query-side, memory-side and core-side signal of the DTW sequencer.
// The sequencer itself uses the slave view; the environment uses the master view.
// There is no logic here, so it adds no latency; handshakes are carried unchanged.
interface dtw_query_sequencer_if #(
  parameter int width = 16
);
  // query control
  logic              start;
  logic [31:0]       ref_len;
  logic              busy;
  // squiggle stream
  logic [width-1:0]  sqg_tdata;
  logic              sqg_tvalid;
  logic              sqg_tready;
  // reference memory, 1-cycle read latency
  logic              ref_rd_en;
  logic [31:0]       ref_addr;
  logic [width-1:0]  ref_rdata;
  // dtw_core connection
  logic              core_rst;
  logic              core_running;
  logic [width-1:0]  core_squiggle;
  logic [width-1:0]  core_rword;
  logic [width-1:0]  core_minval;
  logic [31:0]       core_position;
  logic              core_done;
  // result port
  logic              res_valid;
  logic              res_ready;
  logic [width-1:0]  res_minval;
  logic [31:0]       res_position;

  modport slave (
    input  start, ref_len, sqg_tdata, sqg_tvalid, ref_rdata,
           core_minval, core_position, core_done, res_ready,
    output busy, sqg_tready, ref_rd_en, ref_addr, core_rst, core_running,
           core_squiggle, core_rword, res_valid, res_minval, res_position
  );

  modport master (
    output start, ref_len, sqg_tdata, sqg_tvalid, ref_rdata,
           core_minval, core_position, core_done, res_ready,
    input  busy, sqg_tready, ref_rd_en, ref_addr, core_rst, core_running,
           core_squiggle, core_rword, res_valid, res_minval, res_position
  );
endinterface

// File: rtl/dtw_query_sequencer.sv
// Sequences one dtw_core through a query: load squiggle, stream reference, capture min/position.
// Latency: SQG_SIZE load cycles + core run length + SETTLE+1 cycles from core_done to res_valid.
// Backpressure: sqg_tvalid gaps stall LOAD; res_ready low holds RESULT with res_* stable.
module dtw_query_sequencer #(
  parameter int width    = 16,
  parameter int SQG_SIZE = 250,
  parameter int SETTLE   = 2    // must be >= 1
) (
  input logic                   clk,
  input logic                   rst,
  dtw_query_sequencer_if.slave  bus
);

  localparam int IW = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_RESULT,
    S_CLEAR
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [width-1:0]  sqg_buf [SQG_SIZE];
  logic [IW-1:0]     sidx;          // next buffer slot to fill during LOAD
  logic [31:0]       run_n;         // RUN cycle number, 0 on the first RUN cycle
  logic [31:0]       settle_cnt;    // SETTLE cycles elapsed
  logic [31:0]       ref_len_q;
  logic [width-1:0]  sqg_q;         // buffer word prefetched one cycle ahead of its use
  logic [width-1:0]  res_minval_q;
  logic [31:0]       res_position_q;

  logic              load_last;
  logic              settle_last;

  assign load_last   = bus.sqg_tvalid && (sidx == IW'(SQG_SIZE - 1));
  assign settle_last = (settle_cnt == 32'(SETTLE - 1));

  // The core is held in reset by the global reset and during the one CLEAR cycle.
  assign bus.core_rst     = rst || (state == S_CLEAR);
  assign bus.busy         = (state != S_IDLE);
  assign bus.res_minval   = res_minval_q;
  assign bus.res_position = res_position_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state output drive.
  always_comb begin
    state_nxt         = state;
    bus.sqg_tready    = 1'b0;
    bus.ref_rd_en     = 1'b0;
    bus.ref_addr      = '0;
    bus.core_running  = 1'b0;
    bus.core_squiggle = '0;
    bus.core_rword    = '0;
    bus.res_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.ref_len != 32'd0) ? S_LOAD : S_RESULT;
        end
      end
      S_LOAD: begin
        bus.sqg_tready = 1'b1;
        if (load_last) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.core_running  = 1'b1;
        bus.core_squiggle = sqg_q;
        if (run_n < ref_len_q) begin
          bus.ref_rd_en = 1'b1;
          bus.ref_addr  = run_n;
        end
        // Cycle 0 has no read data yet; after the last word the reference is padded.
        if (run_n == 32'd0) begin
          bus.core_rword = '0;
        end else if (run_n <= ref_len_q) begin
          bus.core_rword = bus.ref_rdata;
        end else begin
          bus.core_rword = '1;
        end
        if (bus.core_done) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Keep the core clocking on padding so its min/position registers settle.
        bus.core_running = 1'b1;
        bus.core_rword   = '1;
        if (settle_last) begin
          state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Squiggle buffer write port; contents need no reset since LOAD refills every slot.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && bus.sqg_tvalid) begin
      sqg_buf[sidx] <= bus.sqg_tdata;
    end
  end

  // Query datapath: sample index, RUN/SETTLE counters, squiggle prefetch, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sidx           <= '0;
      run_n          <= '0;
      settle_cnt     <= '0;
      ref_len_q      <= '0;
      sqg_q          <= '0;
      res_minval_q   <= '1;
      res_position_q <= '0;
    end else begin
      // RUN cycle n presents buffer[n-1], so read slot n during cycle n.
      if ((state == S_RUN) && (run_n < 32'(SQG_SIZE))) begin
        sqg_q <= sqg_buf[run_n[IW-1:0]];
      end else begin
        sqg_q <= '0;
      end

      if (state == S_RUN) begin
        run_n <= run_n + 32'd1;
      end else begin
        run_n <= '0;
      end

      if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 32'd1;
      end else begin
        settle_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ref_len_q <= bus.ref_len;
            sidx      <= '0;
            if (bus.ref_len == 32'd0) begin
              // Empty reference: report "no match" without running the core.
              res_minval_q   <= '1;
              res_position_q <= '0;
            end
          end
        end
        S_LOAD: begin
          if (bus.sqg_tvalid) begin
            sidx <= sidx + IW'(1);
          end
        end
        S_SETTLE: begin
          if (settle_last) begin
            res_minval_q   <= bus.core_minval;
            res_position_q <= bus.core_position;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_query_sequencer.sv
// Directed bench for dtw_query_sequencer with a behavioural subsequence-DTW core and reference memory.
// Expected results are hand-computed constants; cycle-level behaviour is checked against the timing rules.
// Each query exercises load, run, settle, result handshake and clear.
module tb_dtw_query_sequencer;

  localparam int W   = 16;
  localparam int SQG = 4;
  localparam int STL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dtw_query_sequencer_if #(.width(W)) bus ();

  dtw_query_sequencer #(
    .width    (W),
    .SQG_SIZE (SQG),
    .SETTLE   (STL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;

  logic [W-1:0] sq  [SQG];
  logic [W-1:0] mem [64];
  int           cur_rl = 0;

  // Reference memory: data one cycle after the read, garbage otherwise.
  always @(posedge clk) begin
    bus.ref_rdata <= bus.ref_rd_en ? mem[bus.ref_addr[5:0]] : 16'hBAD0;
  end

  // Behavioural core: captures what it is fed, then reports the DTW minimum.
  int           cc;
  logic [W-1:0] cap_sqg [SQG];
  logic [W-1:0] cap_ref [64];

  function automatic logic [47:0] dtw_eval(input int rl);
    int d [SQG][64];
    int c, m, best, bp;
    best = 32'h7fffffff;
    bp   = 0;
    for (int i = 0; i < SQG; i++) begin
      for (int j = 0; j < rl; j++) begin
        c = int'(cap_sqg[i]) - int'(cap_ref[j]);
        if (c < 0) c = -c;
        if (i == 0) begin
          d[i][j] = c;
        end else if (j == 0) begin
          d[i][j] = c + d[i-1][0];
        end else begin
          m = d[i-1][j];
          if (d[i][j-1] < m) m = d[i][j-1];
          if (d[i-1][j-1] < m) m = d[i-1][j-1];
          d[i][j] = c + m;
        end
      end
    end
    for (int j = 0; j < rl; j++) begin
      if (d[SQG-1][j] < best) begin
        best = d[SQG-1][j];
        bp   = j;
      end
    end
    if (best > 65535) best = 65535;
    return {32'(bp), 16'(best)};
  endfunction

  always @(posedge clk) begin
    if (bus.core_rst) begin
      cc                <= 0;
      bus.core_done     <= 1'b0;
      bus.core_minval   <= '1;
      bus.core_position <= '0;
    end else if (bus.core_running) begin
      if (cc >= 1 && cc <= SQG) cap_sqg[cc-1] <= bus.core_squiggle;
      if (cc >= 1 && cc <= cur_rl && cc <= 64) cap_ref[cc-1] <= bus.core_rword;
      if (cc == SQG + cur_rl + 2) begin
        {bus.core_position, bus.core_minval} <= dtw_eval(cur_rl);
        bus.core_done <= 1'b1;
      end
      cc <= cc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One query. abort_at >= 0 asserts rst in that RUN cycle; stall > 0 holds res_ready low.
  task automatic query(input int rl, input bit bubble, input int abort_at, input int stall,
                       input logic [W-1:0] exp_min, input logic [31:0] exp_pos);
    int k, i, lc, kd;
    int bad_load, bad_run, bad_rd, bad_addr, bad_rw, bad_sq, bad_stall;
    logic [W-1:0] exp_rw, exp_sq;
    bit accept;
    bad_load = 0; bad_run = 0; bad_rd = 0; bad_addr = 0; bad_rw = 0; bad_sq = 0; bad_stall = 0;
    cur_rl = rl;
    bus.ref_len = 32'(rl);
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    check("load_tready", bus.sqg_tready, 1);
    check("load_busy", bus.busy, 1);

    i = 0; lc = 0;
    while (i < SQG && lc < 100) begin
      if (bus.sqg_tready !== 1'b1 || bus.core_running !== 1'b0) bad_load++;
      bus.sqg_tvalid = bubble ? (lc % 2 == 0) : 1'b1;
      bus.sqg_tdata  = sq[i];
      accept = bus.sqg_tvalid;
      step();
      lc++;
      if (accept) i++;
    end
    bus.sqg_tvalid = 1'b0;
    check("load_cycles", lc, bubble ? 2 * SQG - 1 : SQG);
    check("load_flags", bad_load, 0);
    check("tready_drop", bus.sqg_tready, 0);

    k = 0; kd = -1;
    while (bus.res_valid !== 1'b1 && k < 200) begin
      if (k == abort_at) begin
        rst = 1'b1;
        step();
        check("abort_running", bus.core_running, 0);
        check("abort_core_rst", bus.core_rst, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_rd_en", bus.ref_rd_en, 0);
        rst = 1'b0;
        step();
        check("abort_core_rst_rel", bus.core_rst, 0);
        return;
      end
      if (bus.core_running !== 1'b1) bad_run++;
      if (bus.ref_rd_en !== (k < rl)) bad_rd++;
      if (bus.ref_addr !== ((k < rl) ? 32'(k) : 32'd0)) bad_addr++;
      exp_rw = (k == 0) ? 16'h0000 : (k <= rl) ? mem[k-1] : 16'hFFFF;
      if (bus.core_rword !== exp_rw) bad_rw++;
      exp_sq = (k >= 1 && k <= SQG) ? sq[k-1] : 16'h0000;
      if (bus.core_squiggle !== exp_sq) bad_sq++;
      if (bus.core_done === 1'b1 && kd < 0) kd = k;
      step();
      k++;
    end
    check("run_timeout", k < 200, 1);
    check("run_running", bad_run, 0);
    check("run_rd_en", bad_rd, 0);
    check("run_addr", bad_addr, 0);
    check("run_rword", bad_rw, 0);
    check("run_squiggle", bad_sq, 0);
    check("done_to_valid", k - kd, STL + 1);
    check("res_minval", bus.res_minval, exp_min);
    check("res_position", bus.res_position, exp_pos);
    check("res_running", bus.core_running, 0);

    for (int s = 0; s < stall; s++) begin
      if (bus.res_valid !== 1'b1 || bus.res_minval !== exp_min || bus.res_position !== exp_pos ||
          bus.sqg_tready !== 1'b0 || bus.busy !== 1'b1) bad_stall++;
      bus.start   = (s == 5);
      bus.ref_len = 32'd2;
      step();
    end
    bus.start = 1'b0;
    if (stall > 0) check("stall_stable", bad_stall, 0);

    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("clear_core_rst", bus.core_rst, 1);
    check("clear_busy", bus.busy, 1);
    check("clear_valid", bus.res_valid, 0);
    step();
    check("idle_busy", bus.busy, 0);
    check("idle_core_rst", bus.core_rst, 0);
    if (stall > 0) begin
      step();
      check("no_late_load", bus.sqg_tready, 0);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.ref_len    = '0;
    bus.sqg_tdata  = '0;
    bus.sqg_tvalid = 1'b0;
    bus.res_ready  = 1'b0;
    for (int j = 0; j < 64; j++) mem[j] = 16'(j * 3 + 1);

    // Reset values.
    rst = 1'b1;
    repeat (3) step();
    check("rst_tready", bus.sqg_tready, 0);
    check("rst_rd_en", bus.ref_rd_en, 0);
    check("rst_running", bus.core_running, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_addr", bus.ref_addr, 0);
    check("rst_squiggle", bus.core_squiggle, 0);
    check("rst_rword", bus.core_rword, 0);
    check("rst_minval", bus.res_minval, 16'hFFFF);
    check("rst_position", bus.res_position, 0);
    check("rst_core_rst", bus.core_rst, 1);
    rst = 1'b0;
    step();
    check("rel_core_rst", bus.core_rst, 0);

    // Full query: exact match of the squiggle at reference words 1..4.
    sq[0] = 16'd10; sq[1] = 16'd20; sq[2] = 16'd30; sq[3] = 16'd40;
    mem[0] = 16'd5; mem[1] = 16'd10; mem[2] = 16'd20; mem[3] = 16'd30; mem[4] = 16'd40; mem[5] = 16'd50;
    query(6, 1'b0, -1, 0, 16'd0, 32'd4);

    // Zero-length reference: immediate "no match" result.
    bus.ref_len = 32'd0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    check("zl_valid", bus.res_valid, 1);
    check("zl_minval", bus.res_minval, 16'hFFFF);
    check("zl_position", bus.res_position, 0);
    check("zl_rd_en", bus.ref_rd_en, 0);
    check("zl_running", bus.core_running, 0);
    step();
    check("zl_hold_running", bus.core_running | bus.ref_rd_en, 0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("zl_clear", bus.core_rst, 1);
    step();
    check("zl_idle", bus.busy, 0);

    // Bubbled squiggle stream, same data and answer.
    query(6, 1'b1, -1, 0, 16'd0, 32'd4);

    // Result backpressure with a second data set (hand DTW: min 2 at word 4).
    sq[0] = 16'd3; sq[1] = 16'd7; sq[2] = 16'd7; sq[3] = 16'd2;
    mem[0] = 16'd1; mem[1] = 16'd3; mem[2] = 16'd8; mem[3] = 16'd6; mem[4] = 16'd2; mem[5] = 16'd9;
    query(6, 1'b0, -1, 20, 16'd2, 32'd4);

    // Reset in RUN cycle 3, then a clean query on the same data.
    query(6, 1'b0, 3, 0, 16'd0, 32'd0);
    query(6, 1'b0, -1, 0, 16'd2, 32'd4);

    // Short reference: address sequence and padding (hand DTW: min 30 at word 2).
    sq[0] = 16'd10; sq[1] = 16'd20; sq[2] = 16'd30; sq[3] = 16'd40;
    mem[0] = 16'd5; mem[1] = 16'd10; mem[2] = 16'd20;
    query(3, 1'b0, -1, 0, 16'd30, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
